// File: rtl/ram32x16_arbiter.sv
// Round-robin two-requester sequencer for a 32x16 single-port distributed RAM.
// After reset it can optionally walk all 32 words writing INIT_VALUE before serving traffic.
module ram32x16_arbiter #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] INIT_VALUE     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [4:0]  addr_a,
  input  logic [15:0] wdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [4:0]  addr_b,
  input  logic [15:0] wdata_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b,
  output logic        busy,
  output logic [4:0]  ram_addr,
  output logic [15:0] ram_d,
  output logic        ram_we,
  input  logic [15:0] ram_o
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_we_q, cmd_we_d;
  logic [4:0]  cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        cmd_id_q, cmd_id_d;
  logic        ram_we_q, ram_we_d;
  logic        rvalid_a_q, rvalid_a_d;
  logic        rvalid_b_q, rvalid_b_d;
  logic [15:0] rdata_a_q, rdata_a_d;
  logic [15:0] rdata_b_q, rdata_b_d;
  logic        cmd_rd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state_q <= ST_CLEAR;
      else                state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == 5'd31) state_d = ST_RUN;
        else                state_d = ST_CLEAR;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Grants are combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    busy  = 1'b0;
    case (state_q)
      ST_CLEAR: busy = 1'b1;
      ST_RUN: begin
        if (req_a && req_b) begin
          gnt_a = ~ptr_q;
          gnt_b = ptr_q;
        end else begin
          gnt_a = req_a;
          gnt_b = req_b;
        end
      end
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    cmd_valid_d = 1'b0;
    cmd_we_d    = 1'b0;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_id_d    = cmd_id_q;
    if (state_q == ST_CLEAR) begin
      cnt_d       = cnt_q + 5'd1;
      cmd_valid_d = 1'b1;
      cmd_we_d    = 1'b1;
      cmd_addr_d  = cnt_q;
      cmd_data_d  = INIT_VALUE;
      cmd_id_d    = 1'b0;
    end else if (gnt_a) begin
      ptr_d       = 1'b1;
      cmd_valid_d = 1'b1;
      cmd_we_d    = we_a;
      cmd_addr_d  = addr_a;
      cmd_data_d  = wdata_a;
      cmd_id_d    = 1'b0;
    end else if (gnt_b) begin
      ptr_d       = 1'b0;
      cmd_valid_d = 1'b1;
      cmd_we_d    = we_b;
      cmd_addr_d  = addr_b;
      cmd_data_d  = wdata_b;
      cmd_id_d    = 1'b1;
    end else begin
      ptr_d       = ptr_q;
    end
    ram_we_d = cmd_valid_d & cmd_we_d;
  end

  // Read data is taken from the RAM at the edge closing the read command cycle.
  always_comb begin
    cmd_rd_s   = cmd_valid_q & ~cmd_we_q;
    rvalid_a_d = cmd_rd_s & ~cmd_id_q;
    rvalid_b_d = cmd_rd_s & cmd_id_q;
    if (rvalid_a_d) rdata_a_d = ram_o;
    else            rdata_a_d = rdata_a_q;
    if (rvalid_b_d) rdata_b_d = ram_o;
    else            rdata_b_d = rdata_b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 5'd0;
      ptr_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 5'd0;
      cmd_data_q  <= 16'h0000;
      cmd_id_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= 16'h0000;
      rdata_b_q   <= 16'h0000;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_id_q    <= cmd_id_d;
      ram_we_q    <= ram_we_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  assign ram_addr = cmd_addr_q;
  assign ram_d    = cmd_data_q;
  assign ram_we   = ram_we_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_ram32x16_arbiter.sv
// Randomized bench for ram32x16_arbiter: a transaction-level reference model predicts grants,
// RAM commands and returned read data cycle by cycle; directed sections cover clear, hazards and reset.
module tb_ram32x16_arbiter;

  localparam bit          CLR_ON = 1'b1;
  localparam logic [15:0] INIT   = 16'hA5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_a, we_a, req_b, we_b;
  logic [4:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_we;
  logic [15:0] rdata_a, rdata_b, ram_d, ram_o;
  logic [4:0]  ram_addr;

  logic        rst2, req_a2, we_a2, req_b2, we_b2;
  logic [4:0]  addr_a2, addr_b2;
  logic [15:0] wdata_a2, wdata_b2;
  logic        gnt_a2, gnt_b2, rvalid_a2, rvalid_b2, busy2, ram_we2;
  logic [15:0] rdata_a2, rdata_b2, ram_d2, ram_o2;
  logic [4:0]  ram_addr2;

  ram32x16_arbiter #(.CLEAR_ON_RESET(CLR_ON), .INIT_VALUE(INIT)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_o(ram_o)
  );

  ram32x16_arbiter #(.CLEAR_ON_RESET(1'b0), .INIT_VALUE(16'h0000)) dut2 (
    .clk(clk), .rst(rst2),
    .req_a(req_a2), .we_a(we_a2), .addr_a(addr_a2), .wdata_a(wdata_a2),
    .req_b(req_b2), .we_b(we_b2), .addr_b(addr_b2), .wdata_b(wdata_b2),
    .gnt_a(gnt_a2), .gnt_b(gnt_b2), .rvalid_a(rvalid_a2), .rvalid_b(rvalid_b2),
    .rdata_a(rdata_a2), .rdata_b(rdata_b2), .busy(busy2),
    .ram_addr(ram_addr2), .ram_d(ram_d2), .ram_we(ram_we2), .ram_o(ram_o2)
  );

  // Behavioural RAM32X16S: synchronous write, asynchronous read.
  logic [15:0] ram1 [32];
  logic [15:0] ram2 [32];
  always @(posedge clk) if (ram_we) ram1[ram_addr] <= ram_d;
  always @(posedge clk) if (ram_we2) ram2[ram_addr2] <= ram_d2;
  assign ram_o  = ram1[ram_addr];
  assign ram_o2 = ram2[ram_addr2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state.
  bit          m_known = 1'b0;
  int          m_phase = 0;
  bit          m_ptr   = 1'b0;
  bit          c_v = 1'b0, c_we = 1'b0, c_id = 1'b0;
  logic [4:0]  c_addr = 5'd0;
  logic [15:0] c_data = 16'h0000;
  bit          r_v = 1'b0, r_id = 1'b0;
  logic [15:0] m_rd_a = 16'h0000, m_rd_b = 16'h0000;
  logic [15:0] m_mem [32];
  bit          obs_ga, obs_gb;

  // One clock cycle: compare outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    bit clearing, ea, eb, nr_v, nr_id;
    logic [15:0] nr_data;
    @(negedge clk);
    obs_ga   = gnt_a;
    obs_gb   = gnt_b;
    clearing = CLR_ON && (m_phase < 32);
    ea = 1'b0;
    eb = 1'b0;
    if (!clearing) begin
      if (req_a && req_b) begin
        ea = !m_ptr;
        eb = m_ptr;
      end else begin
        ea = req_a;
        eb = req_b;
      end
    end
    if (m_known) begin
      check_eq("gnt_a", 32'(gnt_a), 32'(ea));
      check_eq("gnt_b", 32'(gnt_b), 32'(eb));
      check_eq("busy", 32'(busy), 32'(clearing));
      check_eq("ram_we", 32'(ram_we), 32'(c_v && c_we));
      if (c_v) check_eq("ram_addr", 32'(ram_addr), 32'(c_addr));
      if (c_v && c_we) check_eq("ram_d", 32'(ram_d), 32'(c_data));
      check_eq("rvalid_a", 32'(rvalid_a), 32'(r_v && !r_id));
      check_eq("rvalid_b", 32'(rvalid_b), 32'(r_v && r_id));
      check_eq("rdata_a", 32'(rdata_a), 32'(m_rd_a));
      check_eq("rdata_b", 32'(rdata_b), 32'(m_rd_b));
    end
    nr_v = 1'b0;
    nr_id = 1'b0;
    nr_data = 16'h0000;
    if (c_v) begin
      if (c_we) m_mem[c_addr] = c_data;
      else begin
        nr_v = 1'b1;
        nr_id = c_id;
        nr_data = m_mem[c_addr];
      end
    end
    if (rst) begin
      m_known = 1'b1;
      m_phase = 0;
      m_ptr   = 1'b0;
      c_v     = 1'b0;
      r_v     = 1'b0;
      m_rd_a  = 16'h0000;
      m_rd_b  = 16'h0000;
    end else begin
      r_v  = nr_v;
      r_id = nr_id;
      if (nr_v && !nr_id) m_rd_a = nr_data;
      if (nr_v && nr_id)  m_rd_b = nr_data;
      c_v = 1'b0;
      if (clearing) begin
        c_v = 1'b1; c_we = 1'b1; c_addr = 5'(m_phase); c_data = INIT; c_id = 1'b0;
      end else if (ea) begin
        c_v = 1'b1; c_we = we_a; c_addr = addr_a; c_data = wdata_a; c_id = 1'b0; m_ptr = 1'b1;
      end else if (eb) begin
        c_v = 1'b1; c_we = we_b; c_addr = addr_b; c_data = wdata_b; c_id = 1'b1; m_ptr = 1'b0;
      end
      if (m_phase < 1000) m_phase++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int k);
    req_a = 1'b1;
    case (k)
      0:       begin we_a = 1'b0; addr_a = 5'd0;  wdata_a = 16'h0000; end
      1:       begin we_a = 1'b0; addr_a = 5'd31; wdata_a = 16'h0000; end
      2:       begin we_a = 1'b1; addr_a = 5'd5;  wdata_a = 16'h1111; end
      default: req_a = 1'b0;
    endcase
  endtask

  task automatic load_b(input int k);
    req_b = 1'b1;
    case (k)
      0:       begin we_b = 1'b0; addr_b = 5'd17; wdata_b = 16'h0000; end
      1:       begin we_b = 1'b1; addr_b = 5'd9;  wdata_b = 16'h2222; end
      2:       begin we_b = 1'b0; addr_b = 5'd31; wdata_b = 16'h0000; end
      default: req_b = 1'b0;
    endcase
  endtask

  task automatic rand_a();
    req_a = ($urandom_range(0, 3) != 0);
    we_a = 1'($urandom_range(0, 1));
    addr_a = 5'($urandom_range(0, 7));
    wdata_a = 16'($urandom);
  endtask

  task automatic rand_b();
    req_b = ($urandom_range(0, 3) != 0);
    we_b = 1'($urandom_range(0, 1));
    addr_b = 5'($urandom_range(0, 7));
    wdata_b = 16'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt, busy_fall, ia, ib;
    bit order_ok;
    int gseq[$];
    int gcyc[$];

    rst = 1'b1; req_a = 1'b0; we_a = 1'b0; addr_a = 5'd0; wdata_a = 16'h0000;
    req_b = 1'b0; we_b = 1'b0; addr_b = 5'd0; wdata_b = 16'h0000;
    rst2 = 1'b1; req_a2 = 1'b0; we_a2 = 1'b0; addr_a2 = 5'd0; wdata_a2 = 16'h0000;
    req_b2 = 1'b0; we_b2 = 1'b0; addr_b2 = 5'd0; wdata_b2 = 16'h0000;

    step();
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_d", 32'(ram_d), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_rdata_a", 32'(rdata_a), 32'd0);
    step();

    // Clear sequence with both requesters already waiting, then six contended accesses.
    rst = 1'b0;
    ia = 0; ib = 0;
    load_a(0);
    load_b(0);
    we_cnt = 0; order_ok = 1'b1; busy_fall = -1;
    for (int i = 0; i <= 40; i++) begin
      if (i <= 33) begin
        if (i >= 1 && i <= 32) begin
          if (!(ram_we && ram_addr == 5'(i - 1) && ram_d == INIT)) order_ok = 1'b0;
        end else if (ram_we) order_ok = 1'b0;
        if (ram_we) we_cnt++;
      end
      if (busy_fall < 0 && !busy) busy_fall = i;
      if (i == 34) begin
        check_eq("rd0_rvalid_a", 32'(rvalid_a), 32'd1);
        check_eq("rd0_rdata_a", 32'(rdata_a), 32'(INIT));
      end
      if (i == 35) begin
        check_eq("rd17_rvalid_b", 32'(rvalid_b), 32'd1);
        check_eq("rd17_rdata_b", 32'(rdata_b), 32'(INIT));
      end
      if (i == 36) begin
        check_eq("rd31_rdata_a", 32'(rdata_a), 32'(INIT));
        check_eq("wr9_ram_addr", 32'(ram_addr), 32'd9);
        check_eq("wr9_ram_d", 32'(ram_d), 32'h2222);
      end
      if (i == 37) check_eq("wr5_ram_addr", 32'(ram_addr), 32'd5);
      if (i == 39) check_eq("rd31_rdata_b", 32'(rdata_b), 32'(INIT));
      step();
      if (obs_ga) begin gseq.push_back(0); gcyc.push_back(i); ia++; load_a(ia); end
      if (obs_gb) begin gseq.push_back(1); gcyc.push_back(i); ib++; load_b(ib); end
    end
    check_eq("clear_we_cycles", 32'(we_cnt), 32'd32);
    check_eq("clear_addr_order", 32'(order_ok), 32'd1);
    check_eq("busy_fall_cycle", 32'(busy_fall), 32'd32);
    check_eq("grant_count", 32'(gseq.size()), 32'd6);
    for (int k = 0; k < gseq.size(); k++) begin
      check_eq("grant_order", 32'(gseq[k]), 32'(k % 2));
      check_eq("grant_cycle", 32'(gcyc[k]), 32'(32 + k));
    end

    // A writes then immediately reads the same word.
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd4; wdata_a = 16'h0012;
    step();
    check_eq("raw_ram_we", 32'(ram_we), 32'd1);
    check_eq("raw_ram_addr", 32'(ram_addr), 32'd4);
    check_eq("raw_ram_d", 32'(ram_d), 32'h0012);
    we_a = 1'b0;
    step();
    req_a = 1'b0;
    check_eq("raw_read_no_we", 32'(ram_we), 32'd0);
    step();
    check_eq("raw_rvalid_a", 32'(rvalid_a), 32'd1);
    check_eq("raw_rdata_a", 32'(rdata_a), 32'h0012);
    check_eq("raw_rvalid_b", 32'(rvalid_b), 32'd0);

    // A writes, B reads the same word on the next cycle.
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd3; wdata_a = 16'h0006;
    step();
    req_a = 1'b0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd3;
    step();
    req_b = 1'b0;
    step();
    check_eq("xraw_rvalid_b", 32'(rvalid_b), 32'd1);
    check_eq("xraw_rdata_b", 32'(rdata_b), 32'h0006);

    // Reset right after a B write grant, with an A read still in flight.
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd4;
    step();
    req_a = 1'b0;
    req_b = 1'b1; we_b = 1'b1; addr_b = 5'd2; wdata_b = 16'hBEEF;
    rst = 1'b1;
    step();
    check_eq("rst_gnt_b", 32'(obs_gb), 32'd1);
    rst = 1'b0;
    req_b = 1'b0;
    check_eq("rst_no_rvalid_a", 32'(rvalid_a), 32'd0);
    check_eq("rst_no_write", 32'(ram_we), 32'd0);
    check_eq("rst_busy_again", 32'(busy), 32'd1);
    we_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (ram_we) we_cnt++;
    end
    check_eq("reclear_we_cycles", 32'(we_cnt), 32'd32);
    check_eq("reclear_busy_low", 32'(busy), 32'd0);
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd2;
    step();
    req_a = 1'b0;
    step();
    check_eq("addr2_rvalid_a", 32'(rvalid_a), 32'd1);
    check_eq("addr2_rdata_a", 32'(rdata_a), 32'(INIT));

    // Random traffic; requests are held until granted, occasionally withdrawn.
    rand_a();
    rand_b();
    for (int n = 0; n < 400; n++) begin
      step();
      if (obs_ga || !req_a) rand_a();
      else if ($urandom_range(0, 15) == 0) req_a = 1'b0;
      if (obs_gb || !req_b) rand_b();
      else if ($urandom_range(0, 15) == 0) req_b = 1'b0;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    step();
    step();

    // Instance without clear: traffic accepted in the first cycle after reset.
    step();
    check_eq("nc_rst_busy", 32'(busy2), 32'd0);
    check_eq("nc_rst_rvalid_a", 32'(rvalid_a2), 32'd0);
    check_eq("nc_rst_ram_we", 32'(ram_we2), 32'd0);
    rst2 = 1'b0;
    req_a2 = 1'b1; we_a2 = 1'b1; addr_a2 = 5'd7; wdata_a2 = 16'h7777;
    req_b2 = 1'b1; we_b2 = 1'b0; addr_b2 = 5'd1;
    #1;
    check_eq("nc_first_gnt_a", 32'(gnt_a2), 32'd1);
    check_eq("nc_first_gnt_b", 32'(gnt_b2), 32'd0);
    check_eq("nc_busy", 32'(busy2), 32'd0);
    step();
    check_eq("nc_ram_we", 32'(ram_we2), 32'd1);
    check_eq("nc_ram_addr", 32'(ram_addr2), 32'd7);
    check_eq("nc_ram_d", 32'(ram_d2), 32'h7777);
    check_eq("nc_gnt_b_next", 32'(gnt_b2), 32'd1);
    req_b2 = 1'b0;
    we_a2 = 1'b0;
    step();
    req_a2 = 1'b0;
    step();
    check_eq("nc_rvalid_a", 32'(rvalid_a2), 32'd1);
    check_eq("nc_rdata_a", 32'(rdata_a2), 32'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
